// File: rtl/lsu_subword.sv
// Load/store unit bridging core byte/half/word requests onto a word-only data memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
//
// state | meaning
// IDLE  | ready for a request; decodes errors on acceptance
// RD    | word read; load result or merge word captured
// WR    | single-cycle memory write (SW direct, SB/SH merged)
// RESP  | done pulse with rdata/err
module lsu_subword #(
   parameter int MEM_BYTES = 16384
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        MemWrite,
   output logic [31:0] memory_address,
   output logic [31:0] WD2,
   input  logic [31:0] Data
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state, state_nxt;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] merge_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        illegal, misaligned, fault, bad;
   logic        accept;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;
   logic [31:0] wr_word;

   assign accept = req && ready;

   always_comb begin
      illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                   (we && funct3[2]);
      misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      fault      = (addr >= 32'(MEM_BYTES));
      bad        = illegal || misaligned || fault;
   end

   always_comb begin
      byte_sel = Data[{addr_q[1:0], 3'b000} +: 8];
      half_sel = addr_q[1] ? Data[31:16] : Data[15:0];
      case (f3_q)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_val = {24'd0, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_val = {16'd0, half_sel};
         default: load_val = Data;
      endcase
   end

   always_comb begin
      wr_word = merge_q;
      case (f3_q[1:0])
         2'b00:   wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'b01:   wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: wr_word = wdata_q;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (bad)                        state_nxt = RESP;
               else if (!we)                   state_nxt = RD;
               else if (funct3[1:0] == 2'b10)  state_nxt = WR;
               else                            state_nxt = RD;
            end
         end
         RD:      state_nxt = we_q ? WR : RESP;
         WR:      state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         merge_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (accept) begin
                  we_q    <= we;
                  f3_q    <= funct3;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  err_q   <= bad;
                  rdata_q <= 32'd0;
               end
            end
            RD: begin
               if (we_q) merge_q <= Data;
               else      rdata_q <= load_val;
            end
            RESP: begin
               err_q   <= 1'b0;
               rdata_q <= 32'd0;
            end
            default: ;
         endcase
      end
   end

   // Reset gates the memory-side strobes immediately, so a WR cut short by reset never writes.
   always_comb begin
      ready          = rst_n && (state == IDLE);
      done           = rst_n && (state == RESP);
      rdata          = rdata_q;
      err            = err_q;
      MemWrite       = rst_n && (state == WR);
      memory_address = (rst_n && (state == RD || state == WR)) ? {addr_q[31:2], 2'b00} : 32'd0;
      WD2            = (rst_n && (state == WR)) ? wr_word : 32'd0;
   end

endmodule
